// File: rtl/input_row_loader.sv
// Steers a 32-bit activation stream into ROWS row buffers, row 0 first.
// Optional macro ILOAD_TLAST_ABORT_EN: early tlast aborts the tile load.
module input_row_loader #(
    parameter int ROWS          = 32,
    parameter int WORDS_PER_ROW = 7,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              hold,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [ROWS-1:0]   row_wr_en,
    output logic [DATA_W-1:0] row_data,
    output logic              busy,
    output logic              tile_done,
    output logic              err_tlast
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

`ifdef ILOAD_TLAST_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] row_cnt;
    logic [WW-1:0] word_cnt;
    logic          hs;
    logic          last_word;
    logic          last_row;
    logic          final_pos;
    logic          mism;
    logic          abort;

    assign s_axis_tready = (state == LOAD) && !hold;
    assign busy          = (state == LOAD);
    assign tile_done     = (state == DONE);

    assign hs        = s_axis_tvalid && s_axis_tready;
    assign last_word = (word_cnt == WW'(WORDS_PER_ROW - 1));
    assign last_row  = (row_cnt == RW'(ROWS - 1));
    assign final_pos = last_word && last_row;
    assign mism      = hs && (s_axis_tlast != final_pos);
    // Early tlast only; a missing tlast on the final beat never aborts
    assign abort     = ABORT_EN && mism && s_axis_tlast;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (hs && final_pos) begin
                    state_nx = DONE;
                end else if (abort) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_cnt   <= '0;
            word_cnt  <= '0;
            row_wr_en <= '0;
            row_data  <= '0;
            err_tlast <= 1'b0;
        end else begin
            row_wr_en <= '0;
            if (state == IDLE && start) begin
                row_cnt   <= '0;
                word_cnt  <= '0;
                err_tlast <= 1'b0;
            end
            if (hs) begin
                row_wr_en <= ROWS'(1) << row_cnt;
                row_data  <= s_axis_tdata;
                if (mism) begin
                    err_tlast <= 1'b1;
                end
                if (abort || final_pos) begin
                    row_cnt  <= '0;
                    word_cnt <= '0;
                end else if (last_word) begin
                    word_cnt <= '0;
                    row_cnt  <= row_cnt + RW'(1);
                end else begin
                    word_cnt <= word_cnt + WW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_input_row_loader.sv
// Directed vector table plus whole-tile sequences for input_row_loader.
module tb_input_row_loader;

    localparam int ROWS  = 32;
    localparam int WPR   = 7;
    localparam int BEATS = ROWS * WPR;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        hold;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] row_wr_en;
    logic [31:0] row_data;
    logic        busy;
    logic        tile_done;
    logic        err_tlast;

    int n_cmp;
    int n_bad;

    input_row_loader #(
        .ROWS(ROWS),
        .WORDS_PER_ROW(WPR),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .hold(hold),
        .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast),
        .s_axis_tready(tready),
        .row_wr_en(row_wr_en),
        .row_data(row_data),
        .busy(busy),
        .tile_done(tile_done),
        .err_tlast(err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        hd;
        logic        vl;
        logic [31:0] d;
        logic        tr;
        logic        bz;
        logic [31:0] we;
        logic [31:0] rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_wr_en"}, row_wr_en, 32'h0);
        chk({tag, "_data"}, row_data, 32'h0);
        chk({tag, "_tready"}, {31'b0, tready}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, tile_done}, 32'h0);
        chk({tag, "_err"}, {31'b0, err_tlast}, 32'h0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tdata = '0;
        #1;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One whole tile; beats accepted when tvalid && !hold
    task automatic run_tile(input int gap, input int hlo, input int hhi,
                            input int tl_beat, output int done_cyc);
        int beat;
        int cyc;
        int wcnt[ROWS];
        logic acc;
        logic [31:0] exp_we;
        for (int r = 0; r < ROWS; r++) wcnt[r] = 0;
        done_cyc = -1;
        pulse_start();
        chk("tile_busy", {31'b0, busy}, 32'h1);
        chk("tile_err_clr", {31'b0, err_tlast}, 32'h0);
        beat = 0;
        cyc = 0;
        while (1) begin
            hold = (cyc >= hlo) && (cyc < hhi);
            tvalid = (beat < BEATS) && ((gap == 0) || (cyc % 2 == 0));
            tdata = beat;
            tlast = (beat == tl_beat);
            #1;
            chk("tile_tready", {31'b0, tready},
                {31'b0, (beat < BEATS) && !hold});
            @(posedge clk);
            #1;
            acc = tvalid && !hold && (beat < BEATS);
            exp_we = acc ? (32'h1 << (beat / WPR)) : 32'h0;
            chk("tile_wr_en", row_wr_en, exp_we);
            if (acc) begin
                chk("tile_data", row_data, beat);
                beat++;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (row_wr_en[r]) wcnt[r]++;
            end
            chk("tile_done", {31'b0, tile_done},
                {31'b0, acc && (beat == BEATS)});
            if (tile_done) begin
                done_cyc = cyc;
                break;
            end
            cyc++;
            if (cyc > 2000) begin
                chk("tile_timeout", 32'h1, 32'h0);
                break;
            end
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        hold = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            chk("row_writes", wcnt[r], WPR);
        end
        chk("tile_err", {31'b0, err_tlast},
            {31'b0, tl_beat != BEATS - 1});
        @(posedge clk);
        #1;
        chk("post_done", {31'b0, tile_done}, 32'h0);
        chk("post_busy", {31'b0, busy}, 32'h0);
    endtask

    vec_t tbl[12];
    int   d_full;
    int   d_hold;
    int   d_gap;
    int   d_x;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nrst = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tdata = '0;
        #12;
        idle_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'hBB, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h1, 32'h11};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 32'h0, 32'h11};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h33, 1'b1, 1'b1, 32'h0, 32'h11};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h1, 32'h44};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h50, 1'b1, 1'b1, 32'h1, 32'h50};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h51, 1'b1, 1'b1, 32'h1, 32'h51};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h52, 1'b1, 1'b1, 32'h1, 32'h52};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h53, 1'b1, 1'b1, 32'h1, 32'h53};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h54, 1'b1, 1'b1, 32'h1, 32'h54};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h60, 1'b1, 1'b1, 32'h2, 32'h60};
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st;
            hold = tbl[i].hd;
            tvalid = tbl[i].vl;
            tdata = tbl[i].d;
            tlast = 1'b0;
            #1;
            chk("vec_tready", {31'b0, tready}, {31'b0, tbl[i].tr});
            chk("vec_busy", {31'b0, busy}, {31'b0, tbl[i].bz});
            @(posedge clk);
            #1;
            chk("vec_wr_en", row_wr_en, tbl[i].we);
            chk("vec_data", row_data, tbl[i].rd);
            chk("vec_done", {31'b0, tile_done}, 32'h0);
        end
        do_reset();

        run_tile(0, -1, -1, BEATS - 1, d_full);
        chk("full_done_cyc", d_full, BEATS - 1);
        run_tile(0, 10, 15, BEATS - 1, d_hold);
        chk("hold_delay", d_hold - d_full, 5);
        run_tile(1, -1, -1, BEATS - 1, d_gap);
        chk("gap_done_cyc", d_gap, 2 * (BEATS - 1));

`ifdef ILOAD_TLAST_ABORT_EN
        pulse_start();
        for (int b = 0; b <= 20; b++) begin
            tvalid = 1'b1;
            tdata = b;
            tlast = (b == 20);
            @(posedge clk);
            #1;
            chk("abort_wr_en", row_wr_en, 32'h1 << (b / WPR));
            chk("abort_data", row_data, b);
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        chk("abort_err", {31'b0, err_tlast}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, tile_done}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_done2", {31'b0, tile_done}, 32'h0);
        chk("abort_wr_off", row_wr_en, 32'h0);
`else
        run_tile(0, -1, -1, 20, d_x);
        chk("early_done_cyc", d_x, BEATS - 1);
`endif

        run_tile(0, -1, -1, -1, d_x);
        chk("miss_done_cyc", d_x, BEATS - 1);
        run_tile(0, -1, -1, BEATS - 1, d_x);

        pulse_start();
        for (int b = 0; b < 100; b++) begin
            tvalid = 1'b1;
            tdata = b;
            tlast = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("mid_wr_en", row_wr_en, 32'h1 << (99 / WPR));
        nrst = 1'b0;
        #1;
        idle_outputs("midrst");
        tvalid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        run_tile(0, -1, -1, BEATS - 1, d_x);
        chk("reload_done_cyc", d_x, BEATS - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
